// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an NSTAGE-deep in-order pipeline with an
// exception/refetch redirect sequencer, per-stage stall counters and a commit watchdog.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 6,
  parameter int EXC_STAGE  = 4,
  parameter int FLUSH_CYC  = 1,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NSTAGE-1:0]         stall_req,
  input  logic [NSTAGE-1:0]         flush_req,
  input  logic                      exc_req,
  input  logic [PC_W-1:0]           exc_pc,
  input  logic                      refetch_req,
  input  logic [PC_W-1:0]           refetch_pc,
  output logic                      redirect_valid,
  input  logic                      redirect_ready,
  output logic [PC_W-1:0]           redirect_pc,
  output logic [NSTAGE-1:0]         stage_stall,
  output logic [NSTAGE-1:0]         stage_flush,
  output logic                      busy,
  input  logic [$clog2(NSTAGE)-1:0] cnt_sel,
  output logic [CNT_W-1:0]          cnt_val,
  input  logic                      cnt_clr,
  output logic                      wdog_err
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_LIMIT - 1);
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  state_t            state_r;
  logic [FC_W-1:0]   fcnt_r;
  logic              valid_r;
  logic [PC_W-1:0]   pc_r;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r [NSTAGE];
  logic [WD_W-1:0]   run_r;
  logic              wdog_r;

  logic              in_idle_s, in_wait_s, in_flush_s, in_redir_s;
  logic [NSTAGE-1:0] exc_mask_s;
  logic [NSTAGE-1:0] stall_pre_s;
  logic [NSTAGE-1:0] hon_s;
  logic [NSTAGE-1:0] kill_s;
  logic [NSTAGE-1:0] st_s;
  logic [NSTAGE-1:0] fl_s;
  logic              older_stall_s;

  assign in_idle_s  = (state_r == ST_IDLE);
  assign in_wait_s  = (state_r == ST_WAIT);
  assign in_flush_s = (state_r == ST_FLUSH);
  assign in_redir_s = (state_r == ST_REDIR);

  // Request-level stall (an older stall holds all younger stages) plus FSM holds
  always_comb begin
    exc_mask_s    = '0;
    stall_pre_s   = '0;
    hon_s         = '0;
    older_stall_s = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      exc_mask_s[i]  = (i <= EXC_STAGE) ? 1'b1 : 1'b0;
      stall_pre_s[i] = (|(stall_req >> i)) | (in_wait_s & exc_mask_s[i])
                     | (in_redir_s & ((i == 0) ? 1'b1 : 1'b0));
      older_stall_s  = older_stall_s | (stall_req[i] & ~exc_mask_s[i]);
    end
    // A branch flush is only honoured from a stage that is itself moving
    for (int k = 0; k < NSTAGE; k++) begin
      hon_s[k] = flush_req[k] & ~stall_pre_s[k] & (in_idle_s | ~exc_mask_s[k]);
    end
  end

  // Every stage younger than the oldest honoured flusher gets killed
  always_comb begin
    kill_s = '0;
    for (int j = 0; j < NSTAGE; j++) begin
      kill_s[j] = |(hon_s >> (j + 1));
    end
  end

  // Flush beats stall; bubbles fill the gap below a held stage
  always_comb begin
    st_s = stall_pre_s & ~kill_s & ~(in_flush_s ? exc_mask_s : {NSTAGE{1'b0}});
    fl_s = kill_s | (in_flush_s ? exc_mask_s : {NSTAGE{1'b0}});
    fl_s = (fl_s | ((st_s << 1) & ~st_s)) & ~(in_wait_s ? exc_mask_s : {NSTAGE{1'b0}});
    stage_stall = resetn ? st_s : {NSTAGE{1'b0}};
    stage_flush = resetn ? fl_s : {NSTAGE{1'b1}};
  end

  // Exception/refetch sequencer with registered redirect outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      fcnt_r  <= '0;
      valid_r <= 1'b0;
      pc_r    <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (exc_req || refetch_req) begin
            pc_r    <= exc_req ? exc_pc : refetch_pc;
            fcnt_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= older_stall_s ? ST_WAIT : ST_FLUSH;
          end
        end
        ST_WAIT: begin
          fcnt_r <= '0;
          if (!older_stall_s) state_r <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (fcnt_r == FC_LAST) begin
            state_r <= ST_REDIR;
            valid_r <= 1'b1;
          end else begin
            fcnt_r <= fcnt_r + FC_W'(1);
          end
        end
        ST_REDIR: begin
          if (valid_r && redirect_ready) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating per-stage stall counters; clear wins over increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTAGE; i++) begin
      if (!resetn || cnt_clr) begin
        cnt_r[i] <= '0;
      end else if (stage_stall[i] && (cnt_r[i] != CNT_MAX)) begin
        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Commit-stall watchdog; the error is sticky until reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_r  <= '0;
      wdog_r <= 1'b0;
    end else if (stage_stall[NSTAGE-1]) begin
      run_r  <= (run_r == WD_LIM) ? run_r : run_r + WD_W'(1);
      wdog_r <= wdog_r | (run_r == WD_LAST);
    end else begin
      run_r <= '0;
    end
  end

  assign cnt_val        = (int'(cnt_sel) < NSTAGE) ? cnt_r[cnt_sel] : {CNT_W{1'b0}};
  assign redirect_valid = valid_r;
  assign redirect_pc    = pc_r;
  assign busy           = busy_r;
  assign wdog_err       = wdog_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stall/flush resolution, redirect sequencing,
// counters and watchdog. Counters are built 8 bits wide so saturation is reachable quickly.
module tb_pipe_hazard_ctrl;
  localparam int NSTAGE = 6;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NSTAGE-1:0] stall_req, flush_req;
  logic              exc_req, refetch_req, redirect_ready, cnt_clr;
  logic [PC_W-1:0]   exc_pc, refetch_pc;
  logic              redirect_valid, busy, wdog_err;
  logic [PC_W-1:0]   redirect_pc;
  logic [NSTAGE-1:0] stage_stall, stage_flush;
  logic [2:0]        cnt_sel;
  logic [CNT_W-1:0]  cnt_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGE(6), .EXC_STAGE(4), .FLUSH_CYC(1), .PC_W(32),
                     .CNT_W(8), .WDOG_LIMIT(1024)) dut (
    .clk(clk), .resetn(resetn), .stall_req(stall_req), .flush_req(flush_req),
    .exc_req(exc_req), .exc_pc(exc_pc), .refetch_req(refetch_req), .refetch_pc(refetch_pc),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .stage_stall(stage_stall), .stage_flush(stage_flush), .busy(busy),
    .cnt_sel(cnt_sel), .cnt_val(cnt_val), .cnt_clr(cnt_clr), .wdog_err(wdog_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int sel, input logic [CNT_W-1:0] exp);
    cnt_sel = 3'(sel);
    #1;
    chk(tag, 64'(cnt_val), 64'(exp));
  endtask

  initial begin
    resetn = 1'b0; stall_req = 6'h3F; flush_req = 6'h00; exc_req = 1'b0; refetch_req = 1'b0;
    exc_pc = 32'h0; refetch_pc = 32'h0; redirect_ready = 1'b0; cnt_clr = 1'b0; cnt_sel = 3'd0;
    step(); step();
    chk("rst_flush", 64'(stage_flush), 64'h3F);
    chk("rst_stall", 64'(stage_stall), 64'h00);
    chk("rst_valid", 64'(redirect_valid), 64'h0);
    chk("rst_pc", 64'(redirect_pc), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wdog", 64'(wdog_err), 64'h0);
    stall_req = 6'h00;
    resetn = 1'b1;
    step();
    chk_cnt("rst_cnt0", 0, 8'd0);

    // stall from stage 3 for three cycles
    stall_req = 6'b001000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t1_stall", 64'(stage_stall), 64'b001111);
      chk("t1_flush", 64'(stage_flush), 64'b010000);
      step();
    end
    stall_req = 6'h00;
    for (int s = 0; s < NSTAGE; s++) chk_cnt("t1_cnt", s, (s <= 3) ? 8'd3 : 8'd0);

    // branch flush, honoured and blocked
    flush_req = 6'b001000; #1;
    chk("t2_flush", 64'(stage_flush), 64'b000111);
    chk("t2_stall", 64'(stage_stall), 64'b000000);
    stall_req = 6'b100000; #1;
    chk("t2_blk_flush", 64'(stage_flush), 64'b000000);
    chk("t2_blk_stall", 64'(stage_stall), 64'b111111);
    flush_req = 6'b010000; stall_req = 6'b000100; #1;
    chk("t2_beat_flush", 64'(stage_flush), 64'b001111);
    chk("t2_beat_stall", 64'(stage_stall), 64'b000000);
    flush_req = 6'h00; stall_req = 6'h00;

    // exception with no blocking stall
    step();
    exc_req = 1'b1; exc_pc = 32'hBFC00380; redirect_ready = 1'b1;
    step();
    exc_req = 1'b0; exc_pc = 32'h0; #1;
    chk("t3_fl_flush", 64'(stage_flush), 64'b011111);
    chk("t3_fl_stall", 64'(stage_stall), 64'b000000);
    chk("t3_fl_busy", 64'(busy), 64'h1);
    chk("t3_fl_valid", 64'(redirect_valid), 64'h0);
    step();
    chk("t3_rd_valid", 64'(redirect_valid), 64'h1);
    chk("t3_rd_pc", 64'(redirect_pc), 64'hBFC00380);
    chk("t3_rd_stall", 64'(stage_stall), 64'b000001);
    step();
    chk("t3_idle_valid", 64'(redirect_valid), 64'h0);
    chk("t3_idle_busy", 64'(busy), 64'h0);

    // exception blocked by an older stall, then slow redirect acceptance
    redirect_ready = 1'b0; stall_req = 6'b100000;
    exc_req = 1'b1; exc_pc = 32'h12345678;
    step();
    exc_req = 1'b0; exc_pc = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_wait_stall", 64'(stage_stall), 64'b111111);
      chk("t4_wait_flush", 64'(stage_flush), 64'b000000);
      chk("t4_wait_busy", 64'(busy), 64'h1);
      chk("t4_wait_valid", 64'(redirect_valid), 64'h0);
      step();
    end
    stall_req = 6'h00; #1;
    chk("t4_w4_stall", 64'(stage_stall), 64'b011111);
    chk("t4_w4_flush", 64'(stage_flush), 64'b100000);
    step();
    chk("t4_fl_flush", 64'(stage_flush), 64'b011111);
    chk("t4_fl_valid", 64'(redirect_valid), 64'h0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", 64'(redirect_valid), 64'h1);
      chk("t4_hold_pc", 64'(redirect_pc), 64'h12345678);
      step();
    end
    redirect_ready = 1'b1;
    step();
    chk("t4_done_valid", 64'(redirect_valid), 64'h0);
    chk("t4_done_busy", 64'(busy), 64'h0);

    // priority, ignored requests, and reset inside REDIRECT
    redirect_ready = 1'b0;
    exc_req = 1'b1; exc_pc = 32'hAAAA0000; refetch_req = 1'b1; refetch_pc = 32'h55550000;
    step();
    exc_req = 1'b0; refetch_req = 1'b0;
    step();
    chk("t5_prio_pc", 64'(redirect_pc), 64'hAAAA0000);
    refetch_req = 1'b1; refetch_pc = 32'h77770000;
    step();
    refetch_req = 1'b0;
    chk("t5_ign_pc", 64'(redirect_pc), 64'hAAAA0000);
    chk("t5_ign_valid", 64'(redirect_valid), 64'h1);
    flush_req = 6'b000100; #1;
    chk("t5_ign_flush", 64'(stage_flush), 64'b000010);
    flush_req = 6'h00;
    resetn = 1'b0;
    step();
    chk("t5_rst_valid", 64'(redirect_valid), 64'h0);
    chk("t5_rst_busy", 64'(busy), 64'h0);
    resetn = 1'b1; redirect_ready = 1'b1;
    step();
    chk("t5_noreplay", 64'(redirect_valid), 64'h0);

    // watchdog, counter saturation, clear under stall
    stall_req = 6'b100000;
    for (int c = 0; c < 1023; c++) step();
    chk("t6_wdog_pre", 64'(wdog_err), 64'h0);
    step();
    chk("t6_wdog_set", 64'(wdog_err), 64'h1);
    chk_cnt("t6_sat0", 0, 8'hFF);
    step();
    chk_cnt("t6_sat5", 5, 8'hFF);
    stall_req = 6'h00;
    step(); step();
    chk("t6_wdog_sticky", 64'(wdog_err), 64'h1);
    stall_req = 6'b100000; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk_cnt("t6_clr5", 5, 8'd0);
    chk_cnt("t6_clr0", 0, 8'd0);
    step();
    chk_cnt("t6_inc5", 5, 8'd1);
    stall_req = 6'h00; resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t6_wdog_rst", 64'(wdog_err), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
